// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
// Shared definitions for the bit-serial subtractor.
//   ss_state_t : controller state encoding (SS_IDLE, SS_RUN, SS_DONE).
// -----------------------------------------------------------------------------
package serial_sub_pkg;

    typedef enum logic [1:0] {
        SS_IDLE = 2'd0,
        SS_RUN  = 2'd1,
        SS_DONE = 2'd2
    } ss_state_t;

    // Width of a counter that must hold the values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage : serial_sub_pkg

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// One-bit full subtractor built only from two-input NAND gates.
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow in
//   d    : difference bit, a ^ b ^ bin
//   bout : borrow out, (~a & b) | (~(a ^ b) & bin)
// -----------------------------------------------------------------------------
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_n_ab;
    logic w_n_a;
    logic w_n_b;
    logic w_x;      // a ^ b
    logic w_n_xc;
    logic w_n_x;
    logic w_n_c;
    logic w_inv_a;
    logic w_inv_x;
    logic w_t_ab;   // ~(~a & b)
    logic w_t_xc;   // ~(~x & bin)

    // First XOR stage: a ^ b from four NANDs.
    assign w_n_ab  = ~(a & b);
    assign w_n_a   = ~(a & w_n_ab);
    assign w_n_b   = ~(b & w_n_ab);
    assign w_x     = ~(w_n_a & w_n_b);

    // Second XOR stage: (a ^ b) ^ bin.
    assign w_n_xc  = ~(w_x & bin);
    assign w_n_x   = ~(w_x & w_n_xc);
    assign w_n_c   = ~(bin & w_n_xc);
    assign d       = ~(w_n_x & w_n_c);

    // Borrow: NAND of the two inverted product terms gives their OR.
    assign w_inv_a = ~(a & a);
    assign w_inv_x = ~(w_x & w_x);
    assign w_t_ab  = ~(w_inv_a & b);
    assign w_t_xc  = ~(w_inv_x & bin);
    assign bout    = ~(w_t_ab & w_t_xc);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial, LSB-first two's-complement subtractor: diff = a - b, one bit
// per clock, through a single NAND full-subtractor cell and a borrow flop.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : request, sampled only while busy = 0 (IDLE or DONE)
//   a, b   : operands, captured when start is accepted
//   busy   : high while bits are being processed
//   done   : one-cycle pulse when diff/borrow(/ovf) have been updated
//   diff   : a - b modulo 2^WIDTH, held until the next completion
//   borrow : 1 iff unsigned a < b
//   ovf    : signed overflow (only when SERIAL_SUB_OVF_EN is defined)
// Configuration macro: SERIAL_SUB_OVF_EN adds the ovf port and the operand
// MSB capture flops; without it those are not built.
// -----------------------------------------------------------------------------
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ss_state_t          r_state;
    ss_state_t          w_state_nxt;
    logic               w_accept;
    logic               w_last;

    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-2:0]   r_res;     // bits produced so far, newest at the top
    logic [WIDTH-1:0]   w_res_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_bin;
    logic               w_d;
    logic               w_bout;

    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;

`ifdef SERIAL_SUB_OVF_EN
    logic               r_a_msb;
    logic               r_b_msb;
    logic               r_ovf;
`endif

    full_subtractor u_fs (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .bin  (r_bin),
        .d    (w_d),
        .bout (w_bout)
    );

    // The new difference bit enters at the top; after the last bit this is the full result.
    assign w_res_nxt = {w_d, r_res};

    // Next-state decode: accept in IDLE/DONE, finish on the last bit in RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            SS_IDLE: begin
                if (start) begin
                    w_state_nxt = SS_RUN;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = SS_IDLE;
                end
            end
            SS_RUN: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = SS_DONE;
                    w_last      = 1'b1;
                end else begin
                    w_state_nxt = SS_RUN;
                end
            end
            SS_DONE: begin
                if (start) begin
                    w_state_nxt = SS_RUN;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = SS_IDLE;
                end
            end
            default: begin
                w_state_nxt = SS_IDLE;
            end
        endcase
    end

    // State register plus registered busy/done decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SS_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == SS_RUN);
            r_done  <= (w_state_nxt == SS_DONE);
        end
    end

    // Operand shift registers, partial result, bit counter and borrow flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_res  <= '0;
            r_cnt  <= '0;
            r_bin  <= 1'b0;
        end else if (w_accept) begin
            r_a_sh <= a;
            r_b_sh <= b;
            r_res  <= '0;
            r_cnt  <= '0;
            r_bin  <= 1'b0;
        end else if (r_state == SS_RUN) begin
            r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_res  <= w_res_nxt[WIDTH-1:1];
            r_cnt  <= r_cnt + CNT_ONE;
            r_bin  <= w_bout;
        end else begin
            r_a_sh <= r_a_sh;
            r_b_sh <= r_b_sh;
            r_res  <= r_res;
            r_cnt  <= r_cnt;
            r_bin  <= r_bin;
        end
    end

    // Result registers: updated only on the completion edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else if (w_last) begin
            r_diff   <= w_res_nxt;
            r_borrow <= w_bout;
        end else begin
            r_diff   <= r_diff;
            r_borrow <= r_borrow;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are kept because the shift registers lose them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
        end else if (w_accept) begin
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
        end else begin
            r_a_msb <= r_a_msb;
            r_b_msb <= r_b_msb;
        end
    end

    // Overflow: operand signs differ and the result sign differs from a.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
        end else begin
            r_ovf <= r_ovf;
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy   = r_busy;
    assign done   = r_done;
    assign diff   = r_diff;
    assign borrow = r_borrow;

endmodule : serial_subtractor
